// File: rtl/lps_b_stream_loader.sv
// ---------------------------------------------------------------------------
// lps_b_stream_loader
//
// Upstream feeder for the dual B register block. It accepts one packed weight
// word per valid/ready handshake. In LPS mode the word is sent as BEATS beats
// of 2*LANE_W bits. Each beat carries one B1 lane and one B2 lane, top lane
// first, so the downstream shift chains end up with the lanes in their natural
// order. In normal mode the word is sent as a single beat of its low
// 2*LANE_W bits. One cycle after the final beat has been captured downstream,
// w_loaded pulses for a single cycle to mark that B1/B2 hold the whole word.
//
// Ports
//   clk        in   clock, all logic on posedge
//   RSTn       in   synchronous reset, active-low
//   s_valid    in   input word valid
//   s_ready    out  loader can accept a word this cycle
//   s_data     in   [3*LANE_W-1:0]       = B1 image {L2,L1,L0}
//                   [6*LANE_W-1:3*LANE_W] = B2 image {H2,H1,H0}
//   s_lps      in   mode of the offered word (1 = LPS stream, 0 = normal)
//   pause      in   downstream stall, freezes beat sequencing
//   B          out  registered operand to the register block
//   CEB1/CEB2  out  registered clock enables for B1/B2
//   LPS        out  registered mode select, holds the mode of the last word
//   w_loaded   out  one-cycle pulse: B1/B2 now hold the complete word
//   dbg_state  out  {in SEND, current beat index} for observation
//
// Handshake: a word transfers on a rising edge where s_valid && s_ready are
// both 1. s_ready never depends on s_valid. s_ready is high in IDLE and during
// the final beat of a word when pause is low. This lets words stream back to
// back without a bubble.
//
// Pipeline: the FSM state and beat index lead the registered outputs by one
// cycle. A beat selected in cycle c is presented on B/CEB in cycle c+1 and
// captured by the register block on the edge that ends cycle c+1.
// ---------------------------------------------------------------------------
module lps_b_stream_loader #(
  parameter int LANE_W = 9,
  parameter int BEATS  = 3
) (
  input  logic                        clk,
  input  logic                        RSTn,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [2*BEATS*LANE_W-1:0]   s_data,
  input  logic                        s_lps,
  input  logic                        pause,
  output logic [2*LANE_W-1:0]         B,
  output logic                        CEB1,
  output logic                        CEB2,
  output logic                        LPS,
  output logic                        w_loaded,
  output logic [$clog2(BEATS):0]      dbg_state
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int B_W    = 2 * LANE_W;
  localparam int WORD_W = 2 * BEATS * LANE_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic [BEAT_W-1:0]   beat_d;

  logic [WORD_W-1:0]   word_q;
  logic                mode_q;

  // s_ready stays low after reset until the first edge with RSTn high.
  logic                ready_en_q;

  logic [B_W-1:0]      b_q;
  logic                ceb_q;
  logic                last_q;
  logic                lps_q;
  logic                w_loaded_q;

  logic                accept;
  logic                is_final;
  logic                beat_en;
  logic [LANE_W-1:0]   lo_lane;
  logic [LANE_W-1:0]   hi_lane;
  logic [B_W-1:0]      beat_data;

  // ---------------------------------------------------------------------
  // Beat selection
  // ---------------------------------------------------------------------
  // A normal-mode word has only beat 0. For an LPS word, the last beat is
  // BEATS-1.
  assign is_final = mode_q ? (beat_q == BEAT_W'(BEATS - 1)) : (beat_q == '0);

  // Beat k carries lane (BEATS-1-k) of each image, so the top lane leaves first.
  always_comb begin
    lo_lane = '0;
    hi_lane = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BEAT_W'(k)) begin
        lo_lane = word_q[(BEATS - 1 - k) * LANE_W +: LANE_W];
        hi_lane = word_q[(2 * BEATS - 1 - k) * LANE_W +: LANE_W];
      end
    end
  end

  always_comb begin
    beat_data = word_q[B_W-1:0];
    if (mode_q) begin
      beat_data = {hi_lane, lo_lane};
    end
  end

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      IDLE:    s_ready = ready_en_q;
      SEND:    s_ready = ready_en_q & is_final & ~pause;
      default: s_ready = 1'b0;
    endcase
  end

  assign accept = s_valid & s_ready;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and beat strobe
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    beat_en = 1'b0;
    case (state_q)
      IDLE: begin
        // pause is ignored here, so acceptance is never blocked by a stall.
        if (accept) begin
          state_d = SEND;
          beat_d  = '0;
        end
      end
      SEND: begin
        if (!pause) begin
          beat_en = 1'b1;
          if (is_final) begin
            beat_d = '0;
            // If a new word is taken during the final beat, stay in SEND and
            // start it at beat 0 with no idle cycle in between.
            if (!accept) begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Word capture
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      word_q <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      word_q <= s_data;
      mode_q <= s_lps;
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      ready_en_q <= 1'b0;
      b_q        <= '0;
      ceb_q      <= 1'b0;
      last_q     <= 1'b0;
      lps_q      <= 1'b0;
      w_loaded_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      // The final beat is captured on the edge that ends its CEB cycle, so
      // the pulse follows one cycle later. A beat dropped by reset never
      // produces a pulse.
      w_loaded_q <= ceb_q & last_q;
      if (beat_en) begin
        b_q    <= beat_data;
        ceb_q  <= 1'b1;
        last_q <= is_final;
        // The mode changes together with the first enabled beat of a word.
        if (beat_q == '0) begin
          lps_q <= mode_q;
        end
      end else begin
        // B keeps its last value while paused or idle.
        ceb_q  <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end

  assign B         = b_q;
  assign CEB1      = ceb_q;
  assign CEB2      = ceb_q;
  assign LPS       = lps_q;
  assign w_loaded  = w_loaded_q;
  assign dbg_state = {state_q == SEND, beat_q};

endmodule

// File: tb/tb_lps_b_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_lps_b_stream_loader
//
// Self-checking bench for lps_b_stream_loader.
//  - A directed vector table covers reset, one LPS word and one normal word.
//  - Hand-written sequences cover back-to-back words, pause and reset
//    part-way through a word.
//  - A randomized phase drives valid, mode, data, pause and an occasional
//    reset.
// A reference model checks the outputs in every cycle. It keeps a queue of
// the beats still owed for the current word and pops one beat per unpaused
// cycle.
// ---------------------------------------------------------------------------
module tb_lps_b_stream_loader;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_lps = 1'b0;
  logic [53:0] s_data = '0;
  logic        pause = 1'b0;

  logic        s_ready;
  logic [17:0] b;
  logic        ceb1;
  logic        ceb2;
  logic        lps;
  logic        w_loaded;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  lps_b_stream_loader #(.LANE_W(9), .BEATS(3)) dut (
    .clk       (clk),
    .RSTn      (rstn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_lps     (s_lps),
    .pause     (pause),
    .B         (b),
    .CEB1      (ceb1),
    .CEB2      (ceb2),
    .LPS       (lps),
    .w_loaded  (w_loaded),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  // Pending beats of the current word: {first, last, mode, data[17:0]}.
  logic [20:0] exp_q[$];
  logic        m_rdy_en = 1'b0;
  logic [17:0] m_b = '0;
  logic        m_ceb = 1'b0;
  logic        m_last = 1'b0;
  logic        m_lps = 1'b0;
  logic        m_wl = 1'b0;

  // Beat k carries lanes (2-k) and (5-k), counting 9-bit lanes from the LSB.
  function automatic logic [17:0] lps_beat(input logic [53:0] d, input int k);
    logic [8:0] lane [6];
    for (int i = 0; i < 6; i++) lane[i] = d[i*9 +: 9];
    return {lane[5-k], lane[2-k]};
  endfunction

  // The loader is ready when nothing is owed, or only the final beat is owed
  // and it goes out in this cycle.
  function automatic logic model_ready(input logic pz);
    return m_rdy_en && (exp_q.size() == 0 || (exp_q.size() == 1 && !pz));
  endfunction

  task automatic push_word(input logic [53:0] d, input logic mode);
    if (mode) begin
      for (int k = 0; k < 3; k++) exp_q.push_back({k == 0, k == 2, 1'b1, lps_beat(d, k)});
    end else begin
      exp_q.push_back({1'b1, 1'b1, 1'b0, d[17:0]});
    end
  endtask

  always @(posedge clk) begin
    logic        acc;
    logic [20:0] e;
    if (!rstn) begin
      exp_q.delete();
      m_rdy_en = 1'b0;
      m_b = '0; m_ceb = 1'b0; m_last = 1'b0; m_lps = 1'b0; m_wl = 1'b0;
    end else begin
      acc  = s_valid && model_ready(pause);
      m_wl = m_ceb && m_last;
      if (exp_q.size() > 0 && !pause) begin
        e = exp_q.pop_front();
        m_b    = e[17:0];
        m_ceb  = 1'b1;
        m_last = e[19];
        if (e[20]) m_lps = e[18];
      end else begin
        m_ceb  = 1'b0;
        m_last = 1'b0;
      end
      if (acc) push_word(s_data, s_lps);
      m_rdy_en = 1'b1;
    end
  end

  // Scoreboard compare in every cycle, away from the active edge.
  always @(negedge clk) begin
    check("mdl_s_ready", 32'(s_ready), 32'(model_ready(pause)));
    check("mdl_b", 32'(b), 32'(m_b));
    check("mdl_ceb1", 32'(ceb1), 32'(m_ceb));
    check("mdl_ceb2", 32'(ceb2), 32'(m_ceb));
    check("mdl_lps", 32'(lps), 32'(m_lps));
    check("mdl_w_loaded", 32'(w_loaded), 32'(m_wl));
  end

  // Activity log used by the multi-cycle sequences.
  int ceb_run = 0;
  int ceb_max = 0;
  int ceb_total = 0;
  int wl_log[$];

  always @(negedge clk) begin
    if (w_loaded) wl_log.push_back(cyc);
    if (ceb1) begin
      ceb_run++;
      ceb_total++;
      if (ceb_run > ceb_max) ceb_max = ceb_run;
    end else begin
      ceb_run = 0;
    end
  end

  task automatic clear_log();
    ceb_run = 0; ceb_max = 0; ceb_total = 0;
    wl_log.delete();
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // s_valid must already be high. Returns the edge number that performs the
  // transfer, and leaves the caller 1 time unit after that edge.
  task automatic wait_accept(input string name, output int acc_edge);
    bit seen = 1'b0;
    acc_edge = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (s_ready) begin
        seen = 1'b1;
        acc_edge = cyc + 1;
      end
    end
    check(name, 32'(seen), 32'd1);
    next_cycle();
  endtask

  // -------------------------------------------------------------------------
  // Directed vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic        rstn;
    logic        valid;
    logic        lps;
    logic [53:0] data;
    logic        sr;
    logic [17:0] b;
    logic        ceb;
    logic        lpso;
    logic        wl;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic l, input logic [53:0] d,
                              input logic sr, input logic [17:0] eb, input logic ec,
                              input logic el, input logic ew);
    vec_t t;
    t.rstn = r; t.valid = v; t.lps = l; t.data = d;
    t.sr = sr; t.b = eb; t.ceb = ec; t.lpso = el; t.wl = ew;
    return t;
  endfunction

  vec_t vecs[13];

  initial begin
    logic [53:0] w_lps;
    logic [53:0] w_norm;
    logic [53:0] wa, wb, wp, wr, wn;
    logic [63:0] r;
    int a0, a1, a2;

    // lanes 9'h001..9'h006 counting from the LSB
    w_lps  = {9'h006, 9'h005, 9'h004, 9'h003, 9'h002, 9'h001};
    w_norm = {36'hF_0F0F_0F0F, 18'h2ABCD};

    // Outputs in each row result from the inputs of earlier rows.
    // Fields: rstn valid lps data | s_ready B ceb LPS w_loaded
    vecs[0]  = mk(0, 1, 1, w_lps,  0, 18'h00000, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1, w_lps,  0, 18'h00000, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, '0,     0, 18'h00000, 0, 0, 0);
    vecs[3]  = mk(1, 1, 1, w_lps,  1, 18'h00000, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, '0,     0, 18'h00000, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, '0,     0, 18'h00C03, 1, 1, 0);
    vecs[6]  = mk(1, 0, 0, '0,     1, 18'h00A02, 1, 1, 0);
    vecs[7]  = mk(1, 0, 0, '0,     1, 18'h00801, 1, 1, 0);
    vecs[8]  = mk(1, 1, 0, w_norm, 1, 18'h00801, 0, 1, 1);
    vecs[9]  = mk(1, 0, 0, '0,     1, 18'h00801, 0, 1, 0);
    vecs[10] = mk(1, 0, 0, '0,     1, 18'h2ABCD, 1, 0, 0);
    vecs[11] = mk(1, 0, 0, '0,     1, 18'h2ABCD, 0, 0, 1);
    vecs[12] = mk(1, 0, 0, '0,     1, 18'h2ABCD, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      next_cycle();
      rstn    = vecs[i].rstn;
      s_valid = vecs[i].valid;
      s_lps   = vecs[i].lps;
      s_data  = vecs[i].data;
      pause   = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].sr));
      check($sformatf("vec%0d_b", i), 32'(b), 32'(vecs[i].b));
      check($sformatf("vec%0d_ceb1", i), 32'(ceb1), 32'(vecs[i].ceb));
      check($sformatf("vec%0d_ceb2", i), 32'(ceb2), 32'(vecs[i].ceb));
      check($sformatf("vec%0d_lps", i), 32'(lps), 32'(vecs[i].lpso));
      check($sformatf("vec%0d_w_loaded", i), 32'(w_loaded), 32'(vecs[i].wl));
    end

    // ---- back-to-back LPS words with s_valid held high --------------------
    wa = {9'h111, 9'h122, 9'h133, 9'h144, 9'h155, 9'h166};
    wb = {9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD, 9'h0EE, 9'h0FF};
    next_cycle();
    s_valid = 1'b0;
    next_cycle();
    clear_log();
    s_valid = 1'b1; s_lps = 1'b1; s_data = wa;
    wait_accept("b2b_accept_a", a0);
    s_data = wb;
    wait_accept("b2b_accept_b", a1);
    s_valid = 1'b0;
    repeat (8) next_cycle();
    check("b2b_accept_gap", 32'(a1 - a0), 32'd3);
    check("b2b_ceb_run", 32'(ceb_max), 32'd6);
    check("b2b_wl_count", 32'(wl_log.size()), 32'd2);
    if (wl_log.size() == 2) begin
      check("b2b_wl_first", 32'(wl_log[0] - a0), 32'd4);
      check("b2b_wl_gap", 32'(wl_log[1] - wl_log[0]), 32'd3);
    end

    // ---- pause for 2 cycles while beat 1 is on B ---------------------------
    wp = {9'h1A1, 9'h1A2, 9'h1A3, 9'h1B1, 9'h1B2, 9'h1B3};
    clear_log();
    s_valid = 1'b1; s_lps = 1'b1; s_data = wp;
    wait_accept("pause_accept", a0);
    s_valid = 1'b0;
    next_cycle();              // beat 0 on B
    next_cycle();              // beat 1 on B
    pause = 1'b1;
    @(negedge clk);
    check("pause_b_beat1", 32'(b), 32'(lps_beat(wp, 1)));
    next_cycle();
    @(negedge clk);
    check("pause_hold_b", 32'(b), 32'(lps_beat(wp, 1)));
    check("pause_hold_ceb", 32'(ceb1), 32'd0);
    next_cycle();
    pause = 1'b0;
    repeat (6) next_cycle();
    check("pause_ceb_total", 32'(ceb_total), 32'd3);
    check("pause_wl_count", 32'(wl_log.size()), 32'd1);
    if (wl_log.size() == 1) check("pause_wl_slip", 32'(wl_log[0] - a0), 32'd6);

    // ---- reset while beat 1 is on B -----------------------------------------
    wr = {9'h0F1, 9'h0F2, 9'h0F3, 9'h0F4, 9'h0F5, 9'h0F6};
    wn = {9'h013, 9'h057, 9'h09B, 9'h0DF, 9'h123, 9'h167};
    clear_log();
    s_valid = 1'b1; s_lps = 1'b1; s_data = wr;
    wait_accept("rst_accept", a0);
    s_valid = 1'b0;
    next_cycle();
    next_cycle();
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    check("rst_mid_b", 32'(b), 32'd0);
    check("rst_mid_ceb", 32'(ceb1), 32'd0);
    check("rst_mid_s_ready", 32'(s_ready), 32'd0);
    repeat (6) next_cycle();
    check("rst_mid_no_wl", 32'(wl_log.size()), 32'd0);
    s_valid = 1'b1; s_lps = 1'b1; s_data = wn;
    wait_accept("rst_next_accept", a2);
    s_valid = 1'b0;
    @(negedge clk);            // cycle a2: nothing presented yet
    next_cycle();
    @(negedge clk);            // cycle a2+1: beat 0
    check("rst_next_beat0", 32'(b), 32'(lps_beat(wn, 0)));
    check("rst_next_ceb", 32'(ceb1), 32'd1);
    repeat (5) next_cycle();
    check("rst_next_wl_count", 32'(wl_log.size()), 32'd1);
    if (wl_log.size() == 1) check("rst_next_wl_time", 32'(wl_log[0] - a2), 32'd4);

    // ---- randomized phase ---------------------------------------------------
    for (int i = 0; i < 1500; i++) begin
      next_cycle();
      rstn    = ($urandom_range(0, 199) != 0);
      s_valid = ($urandom_range(0, 9) < 7);
      s_lps   = ($urandom_range(0, 3) != 0);
      r       = {$urandom(), $urandom()};
      s_data  = r[53:0];
      pause   = ($urandom_range(0, 4) == 0);
    end
    next_cycle();
    rstn = 1'b1; s_valid = 1'b0; pause = 1'b0;
    repeat (8) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
